debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  N-channel switch/button debouncer, parametrised successor to the single-channel debouncer.
//  Per channel: 2-FF synchroniser, stability counter, registered debounced level and one-cycle rise/fall pulses.
//  Optional input inversion for active-low buttons and a configurable reset level.
//  Sits between raw board buttons/switches and control FSMs; one instance covers a full button bank.
// PARAMETERS
//  N_CH          4       number of independent channels (>=1)
//  CNT_W         20      stability counter width per channel
//  STABLE_CYCLES 500000  consecutive stable cycles required to accept a change; 1 <= value <= 2^CNT_W-1
//  INIT_LEVEL    0       reset value of sync stages and btn_level, post-inversion (applies to all channels)
//  INVERT        0       1: btn_in inverted before sync (active-low buttons)
// PORTS
//  clk        in   1     system clock; the only clock
//  rst_n      in   1     reset, asynchronous assert, active-low
//  btn_in     in   N_CH  raw asynchronous inputs
//  btn_level  out  N_CH  debounced level, registered
//  btn_rise   out  N_CH  one-cycle pulse on debounced 0->1, registered
//  btn_fall   out  N_CH  one-cycle pulse on debounced 1->0, registered
//  any_event  out  1     OR of all btn_rise|btn_fall bits (combinational from registers)
// BEHAVIOUR
//  Reset (rst_n=0, async): s1,s2 <= {N_CH{INIT_LEVEL}}; cnt <= 0; btn_level <= {N_CH{INIT_LEVEL}};
//   btn_rise, btn_fall <= 0; any_event = 0. No pulse is generated by reset entry or exit.
//  Per channel i, every posedge clk (no shared state between channels):
//   s1 <= btn_in[i] ^ INVERT; s2 <= s1.
//   if s2 == btn_level[i]: cnt <= 0; pulses 0.
//   elif cnt == STABLE_CYCLES-1: cnt <= 0; btn_level[i] <= s2; btn_rise[i] <= s2; btn_fall[i] <= ~s2.
//   else: cnt <= cnt+1; pulses 0.
//  Latency: new value captured into s1 at edge 0 -> btn_level/pulse update at edge STABLE_CYCLES+1.
//  Glitch rejection: any single cycle with s2 == btn_level clears cnt; count restarts from 0.
//  Counter never wraps: clears at STABLE_CYCLES-1; never exceeds STABLE_CYCLES-1.
//  STABLE_CYCLES=1: btn_level follows s2 with one cycle delay (edge 2 after capture).
//  Pulses high exactly one cycle per accepted change; rise and fall never both high on one channel.
//  Simultaneous changes on several channels: each channel pulses independently, same cycle if aligned.
//  Reset mid-count: count lost; after release a still-differing input needs full STABLE_CYCLES again.
//  Illegal parameters (STABLE_CYCLES<1 or >2^CNT_W-1, N_CH<1): elaboration-time error.
// TESTING  (bench overrides STABLE_CYCLES=4, N_CH=4, CNT_W=4 unless noted)
//  1 rst_n=0, btn_in=0 -> all outputs 0; release, hold btn_in=0 20 cycles -> no pulses, any_event=0.
//  2 btn_in[0] 0->1 held -> btn_level[0]=1 and btn_rise[0]=1 for one cycle at edge 5; any_event same cycle; ch1-3 unchanged.
//  3 btn_in[1] high 3 cycles then low -> btn_level[1] stays 0, no pulses; high 10 cycles -> rise at edge 5.
//  4 levels ch2=1, ch3=0; toggle both same cycle -> btn_fall[2] and btn_rise[3] high in the same cycle.
//  5 btn_in[0]=1, assert rst_n at cnt=2 -> outputs to 0 immediately; release with input high -> rise at edge 5 after release.
//  6 INVERT=1, INIT_LEVEL=0: btn_in=1 idle -> no events; drive btn_in=0 -> btn_level=1, btn_rise at edge 5; back to 1 -> btn_fall.

Source files
------------

// File: rtl/debounce_multi.sv
// ----------------------------------------------------------------------------
// debounce_multi
//   Multi-channel debouncer for a bank of raw switches/buttons. Each channel
//   has its own 2-FF synchroniser, stability timer, registered debounced level
//   and one-cycle rise/fall pulses. There is no shared state between channels.
//
// Parameters
//   N_CH          number of independent channels (>= 1)
//   CNT_W         stability timer width per channel
//   STABLE_CYCLES consecutive stable cycles needed to accept a change
//                 (1 .. 2^CNT_W-1)
//   INIT_LEVEL    reset value of the sync stages and btn_level (post-inversion)
//   INVERT        1: btn_in is inverted before the synchroniser (active-low)
//
// Ports
//   clk        in   1     system clock
//   rst_n      in   1     asynchronous active-low reset
//   btn_in     in   N_CH  raw asynchronous inputs
//   btn_level  out  N_CH  debounced level (registered)
//   btn_rise   out  N_CH  one-cycle pulse on accepted 0->1 (registered)
//   btn_fall   out  N_CH  one-cycle pulse on accepted 1->0 (registered)
//   any_event  out  1     OR of all rise/fall bits
// ----------------------------------------------------------------------------
module debounce_multi #(
   parameter int N_CH          = 4,
   parameter int CNT_W         = 20,
   parameter int STABLE_CYCLES = 500000,
   parameter bit INIT_LEVEL    = 1'b0,
   parameter bit INVERT        = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic            any_event
);

   localparam longint unsigned CNT_MAX =
      (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);

   // The timer counts down from STABLE_CYCLES-1; reaching zero while the
   // synchronised input still differs from the level accepts the change.
   // This is cycle-equivalent to counting up to STABLE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

   if (N_CH < 1) begin : g_bad_nch
      $error("debounce_multi: N_CH must be >= 1");
   end

   if ((STABLE_CYCLES < 1) || (64'(STABLE_CYCLES) > CNT_MAX)) begin : g_bad_stable
      $error("debounce_multi: STABLE_CYCLES must be in 1 .. 2^CNT_W-1");
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic             w_in;
      logic             r_s1;
      logic             r_s2;
      logic             r_level;
      logic             r_rise;
      logic             r_fall;
      logic [CNT_W-1:0] r_cnt;

      assign w_in = btn_in[ch] ^ INVERT;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s1    <= INIT_LEVEL;
            r_s2    <= INIT_LEVEL;
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= CNT_LOAD;
         end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
            if (r_s2 == r_level) begin
               // any cycle agreeing with the level restarts the stability window
               r_cnt  <= CNT_LOAD;
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end else if (r_cnt == '0) begin
               r_cnt   <= CNT_LOAD;
               r_level <= r_s2;
               r_rise  <= r_s2;
               r_fall  <= ~r_s2;
            end else begin
               r_cnt  <= r_cnt - 1'b1;
               r_rise <= 1'b0;
               r_fall <= 1'b0;
            end
         end
      end

      assign btn_level[ch] = r_level;
      assign btn_rise[ch]  = r_rise;
      assign btn_fall[ch]  = r_fall;
   end

   assign any_event = |(btn_rise | btn_fall);

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

   localparam int N   = 4;
   localparam int SC  = 4;
   localparam int CW  = 4;
   // input changed at a negedge with cycle count k -> output visible at k+LAT
   localparam int LAT = SC + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn = '0;
   logic [N-1:0] btn_n = '1;

   logic [N-1:0] lvl_n, rise_n, fall_n;
   logic         ev_n;
   logic [N-1:0] lvl_i, rise_i, fall_i;
   logic         ev_i;

   debounce_multi #(.N_CH(N), .CNT_W(CW), .STABLE_CYCLES(SC),
                    .INIT_LEVEL(1'b0), .INVERT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn),
      .btn_level(lvl_n), .btn_rise(rise_n), .btn_fall(fall_n), .any_event(ev_n));

   debounce_multi #(.N_CH(N), .CNT_W(CW), .STABLE_CYCLES(SC),
                    .INIT_LEVEL(1'b0), .INVERT(1'b1)) dut_inv (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_n),
      .btn_level(lvl_i), .btn_rise(rise_i), .btn_fall(fall_i), .any_event(ev_i));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int           cyc;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] level;
   } ev_t;

   ev_t          q_n[$];
   ev_t          q_i[$];
   logic [N-1:0] exp_lvl_n = '0;
   logic [N-1:0] exp_lvl_i = '0;
   int           errors = 0;
   int           checks = 0;

   // scoreboard for the non-inverting instance: pulses expected only on the
   // cycles pushed by the stimulus, zero everywhere else
   always @(negedge clk) begin
      ev_t          e;
      logic [N-1:0] er, ef;
      er = '0;
      ef = '0;
      if (q_n.size() > 0 && q_n[0].cyc == cyc) begin
         e = q_n.pop_front();
         er = e.rise;
         ef = e.fall;
         exp_lvl_n = e.level;
      end
      checks += 4;
      if (rise_n !== er) begin
         errors++;
         $display("FAIL rise_n cyc=%0d got=%b exp=%b", cyc, rise_n, er);
      end
      if (fall_n !== ef) begin
         errors++;
         $display("FAIL fall_n cyc=%0d got=%b exp=%b", cyc, fall_n, ef);
      end
      if (lvl_n !== exp_lvl_n) begin
         errors++;
         $display("FAIL level_n cyc=%0d got=%b exp=%b", cyc, lvl_n, exp_lvl_n);
      end
      if (ev_n !== |(er | ef)) begin
         errors++;
         $display("FAIL any_event_n cyc=%0d got=%b exp=%b", cyc, ev_n, |(er | ef));
      end
   end

   // scoreboard for the inverting instance
   always @(negedge clk) begin
      ev_t          e;
      logic [N-1:0] er, ef;
      er = '0;
      ef = '0;
      if (q_i.size() > 0 && q_i[0].cyc == cyc) begin
         e = q_i.pop_front();
         er = e.rise;
         ef = e.fall;
         exp_lvl_i = e.level;
      end
      checks += 4;
      if (rise_i !== er) begin
         errors++;
         $display("FAIL rise_i cyc=%0d got=%b exp=%b", cyc, rise_i, er);
      end
      if (fall_i !== ef) begin
         errors++;
         $display("FAIL fall_i cyc=%0d got=%b exp=%b", cyc, fall_i, ef);
      end
      if (lvl_i !== exp_lvl_i) begin
         errors++;
         $display("FAIL level_i cyc=%0d got=%b exp=%b", cyc, lvl_i, exp_lvl_i);
      end
      if (ev_i !== |(er | ef)) begin
         errors++;
         $display("FAIL any_event_i cyc=%0d got=%b exp=%b", cyc, ev_i, |(er | ef));
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      btn   = '0;
      btn_n = '1;
      repeat (3) @(negedge clk);
      #1;
      checks += 2;
      if ({lvl_n, rise_n, fall_n, ev_n} !== '0) begin
         errors++;
         $display("FAIL reset_out_n got=%b exp=0", {lvl_n, rise_n, fall_n, ev_n});
      end
      if ({lvl_i, rise_i, fall_i, ev_i} !== '0) begin
         errors++;
         $display("FAIL reset_out_i got=%b exp=0", {lvl_i, rise_i, fall_i, ev_i});
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (lvl_n !== 4'b0000) begin
         errors++;
         $display("FAIL idle_level got=%b exp=0000", lvl_n);
      end
   endtask

   task automatic test_rise();
      @(negedge clk);
      btn[0] = 1'b1;
      q_n.push_back('{cyc + LAT, 4'b0001, 4'b0000, 4'b0001});
      repeat (LAT + 4) @(negedge clk);
      checks++;
      if (lvl_n !== 4'b0001) begin
         errors++;
         $display("FAIL rise_level got=%b exp=0001", lvl_n);
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      btn[1] = 1'b1;
      repeat (SC - 1) @(negedge clk);
      btn[1] = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (lvl_n[1] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_level got=%b exp=0", lvl_n[1]);
      end
      btn[1] = 1'b1;
      q_n.push_back('{cyc + LAT, 4'b0010, 4'b0000, 4'b0011});
      repeat (10) @(negedge clk);
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      btn[2] = 1'b1;
      q_n.push_back('{cyc + LAT, 4'b0100, 4'b0000, 4'b0111});
      repeat (LAT + 4) @(negedge clk);
      btn[2] = 1'b0;
      btn[3] = 1'b1;
      q_n.push_back('{cyc + LAT, 4'b1000, 4'b0100, 4'b1011});
      repeat (LAT + 4) @(negedge clk);
      checks++;
      if (lvl_n !== 4'b1011) begin
         errors++;
         $display("FAIL simul_level got=%b exp=1011", lvl_n);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      btn[0] = 1'b0;
      q_n.push_back('{cyc + LAT, 4'b0000, 4'b0001, 4'b1010});
      repeat (LAT + 4) @(negedge clk);
      btn[0] = 1'b1;
      // four edges later channel 0 has counted two stable cycles
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      exp_lvl_n = '0;
      exp_lvl_i = '0;
      #1;
      checks++;
      if ({lvl_n, rise_n, fall_n, ev_n} !== '0) begin
         errors++;
         $display("FAIL reset_mid_out got=%b exp=0", {lvl_n, rise_n, fall_n, ev_n});
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      q_n.push_back('{cyc + LAT, 4'b1011, 4'b0000, 4'b1011});
      repeat (LAT + 4) @(negedge clk);
      checks++;
      if (lvl_n !== 4'b1011) begin
         errors++;
         $display("FAIL reset_mid_level got=%b exp=1011", lvl_n);
      end
   endtask

   task automatic test_invert();
      @(negedge clk);
      btn_n[0] = 1'b0;
      q_i.push_back('{cyc + LAT, 4'b0001, 4'b0000, 4'b0001});
      repeat (LAT + 4) @(negedge clk);
      checks++;
      if (lvl_i !== 4'b0001) begin
         errors++;
         $display("FAIL invert_level got=%b exp=0001", lvl_i);
      end
      btn_n[0] = 1'b1;
      q_i.push_back('{cyc + LAT, 4'b0000, 4'b0001, 4'b0000});
      repeat (LAT + 4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_invert();
      checks++;
      if (q_n.size() + q_i.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got=%0d exp=0 pending events", q_n.size() + q_i.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
